// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared multicycle MIPS types: controller state encoding, opcodes
//            and datapath select encodings.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_IWB     = 4'd10,
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12,
        S_ORIEX   = 4'd13
    } state_t;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;

    // aluop classes consumed by the existing ALU decoder
    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;
    localparam logic [1:0] c_aluop_or    = 2'b11;

    localparam logic [1:0] c_srcb_reg   = 2'b00;
    localparam logic [1:0] c_srcb_four  = 2'b01;
    localparam logic [1:0] c_srcb_imm   = 2'b10;
    localparam logic [1:0] c_srcb_immsh = 2'b11;

    localparam logic [1:0] c_pc_alu    = 2'b00;
    localparam logic [1:0] c_pc_aluout = 2'b01;
    localparam logic [1:0] c_pc_jump   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mc_maindec_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_maindec_if
// Purpose  : Controller <-> datapath bundle for the multicycle main decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface mc_maindec_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       pcwrite;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       alusrca;
    logic       regdst;
    logic       memtoreg;
    logic       branch;
    logic       bne;
    logic       ori;
    logic       illegal;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic [3:0] state;

    modport slave (
        input  op, mem_ready,
        output pcwrite, irwrite, memwrite, regwrite, iord, alusrca, regdst,
               memtoreg, branch, bne, ori, illegal, alusrcb, pcsrc, aluop, state
    );

    modport master (
        output op, mem_ready,
        input  pcwrite, irwrite, memwrite, regwrite, iord, alusrca, regdst,
               memtoreg, branch, bne, ori, illegal, alusrcb, pcsrc, aluop, state
    );
endinterface
`default_nettype wire

// File: rtl/mc_maindec.sv
`default_nettype none
// ============================================================================
// Module   : mc_maindec
// Purpose  : Moore main-decoder FSM for the multicycle MIPS controller.
// Revision : 1.0 - initial release
// ============================================================================
module mc_maindec
    import mips_pkg::*;
#(
    parameter int SUPPORT_BNE = 1,
    parameter int SUPPORT_ORI = 1
) (
    input  wire          clk,
    input  wire          reset,
    mc_maindec_if.slave  bus
);

    state_t     r_state;
    state_t     w_next;
    logic       w_pcwrite, w_irwrite, w_memwrite, w_regwrite, w_iord, w_alusrca;
    logic       w_regdst, w_memtoreg, w_branch, w_bne, w_ori, w_illegal;
    logic [1:0] w_alusrcb, w_pcsrc, w_aluop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = S_FETCH;
        w_pcwrite  = 1'b0;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_iord     = 1'b0;
        w_alusrca  = 1'b0;
        w_regdst   = 1'b0;
        w_memtoreg = 1'b0;
        w_branch   = 1'b0;
        w_bne      = 1'b0;
        w_ori      = 1'b0;
        w_illegal  = 1'b0;
        w_alusrcb  = c_srcb_reg;
        w_pcsrc    = c_pc_alu;
        w_aluop    = c_aluop_add;
        case (r_state)
            S_FETCH: begin
                w_alusrcb = c_srcb_four;
                w_irwrite = bus.mem_ready;
                w_pcwrite = bus.mem_ready;
                w_next    = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_alusrcb = c_srcb_immsh;
                case (bus.op)
                    c_op_lw, c_op_sw: w_next = S_MEMADR;
                    c_op_rtype:       w_next = S_RTYPEEX;
                    c_op_beq:         w_next = S_BEQEX;
                    c_op_addi:        w_next = S_ADDIEX;
                    c_op_j:           w_next = S_JEX;
                    c_op_bne: begin
                        if (SUPPORT_BNE != 0) w_next    = S_BNEEX;
                        else                  w_illegal = 1'b1;
                    end
                    c_op_ori: begin
                        if (SUPPORT_ORI != 0) w_next    = S_ORIEX;
                        else                  w_illegal = 1'b1;
                    end
                    default:          w_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = c_srcb_imm;
                if (bus.op == c_op_lw)      w_next = S_MEMRD;
                else if (bus.op == c_op_sw) w_next = S_MEMWR;
            end
            S_MEMRD: begin
                w_iord = 1'b1;
                w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
            end
            S_MEMWR: begin
                // write strobe is held for the whole access, not just the last cycle
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
                w_next     = bus.mem_ready ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                w_alusrca = 1'b1;
                w_aluop   = c_aluop_funct;
                w_next    = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BEQEX, S_BNEEX: begin
                w_alusrca = 1'b1;
                w_aluop   = c_aluop_sub;
                w_pcsrc   = c_pc_aluout;
                w_branch  = (r_state == S_BEQEX);
                w_bne     = (r_state == S_BNEEX);
            end
            S_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = c_srcb_imm;
                w_next    = S_IWB;
            end
            S_ORIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = c_srcb_imm;
                w_aluop   = c_aluop_or;
                w_ori     = 1'b1;
                w_next    = S_IWB;
            end
            S_IWB: begin
                w_regwrite = 1'b1;
            end
            S_JEX: begin
                w_pcsrc   = c_pc_jump;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // write enables are forced low while reset is held, even in FETCH with mem_ready high
    assign bus.pcwrite  = w_pcwrite  & ~reset;
    assign bus.irwrite  = w_irwrite  & ~reset;
    assign bus.memwrite = w_memwrite & ~reset;
    assign bus.regwrite = w_regwrite & ~reset;
    assign bus.illegal  = w_illegal  & ~reset;
    assign bus.iord     = w_iord;
    assign bus.alusrca  = w_alusrca;
    assign bus.regdst   = w_regdst;
    assign bus.memtoreg = w_memtoreg;
    assign bus.branch   = w_branch;
    assign bus.bne      = w_bne;
    assign bus.ori      = w_ori;
    assign bus.alusrcb  = w_alusrcb;
    assign bus.pcsrc    = w_pcsrc;
    assign bus.aluop    = w_aluop;
    assign bus.state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_maindec.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_maindec
// Purpose  : Scoreboard bench for mc_maindec (full-featured and reduced builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_maindec;

    // expected-output bit masks, packed as {pcwrite..illegal, alusrcb, pcsrc, aluop}
    localparam logic [17:0] c_pcw  = 18'h20000;
    localparam logic [17:0] c_irw  = 18'h10000;
    localparam logic [17:0] c_mw   = 18'h08000;
    localparam logic [17:0] c_rw   = 18'h04000;
    localparam logic [17:0] c_iord = 18'h02000;
    localparam logic [17:0] c_asa  = 18'h01000;
    localparam logic [17:0] c_rdst = 18'h00800;
    localparam logic [17:0] c_m2r  = 18'h00400;
    localparam logic [17:0] c_br   = 18'h00200;
    localparam logic [17:0] c_bne  = 18'h00100;
    localparam logic [17:0] c_ori  = 18'h00080;
    localparam logic [17:0] c_ill  = 18'h00040;
    localparam logic [17:0] c_sb1  = 18'h00010;
    localparam logic [17:0] c_sb2  = 18'h00020;
    localparam logic [17:0] c_sb3  = 18'h00030;
    localparam logic [17:0] c_pc1  = 18'h00004;
    localparam logic [17:0] c_pc2  = 18'h00008;
    localparam logic [17:0] c_ao1  = 18'h00001;
    localparam logic [17:0] c_ao2  = 18'h00002;
    localparam logic [17:0] c_ao3  = 18'h00003;
    localparam logic [17:0] c_fet  = c_pcw | c_irw | c_sb1;

    localparam logic [5:0] c_lw = 6'b100011, c_sw = 6'b101011, c_rt = 6'b000000;
    localparam logic [5:0] c_beq = 6'b000100, c_bneop = 6'b000101, c_addi = 6'b001000;
    localparam logic [5:0] c_oriop = 6'b001101, c_j = 6'b000010, c_bad = 6'b111111;

    typedef struct {
        int          sel;
        logic [3:0]  st;
        logic [17:0] o;
        string       nm;
    } sb_entry_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   queued;
    sb_entry_t sb[$];

    mc_maindec_if b0 ();
    mc_maindec_if b1 ();

    mc_maindec #(.SUPPORT_BNE(1), .SUPPORT_ORI(1)) u_full (
        .clk   (clk),
        .reset (reset),
        .bus   (b0.slave)
    );

    mc_maindec #(.SUPPORT_BNE(0), .SUPPORT_ORI(0)) u_lite (
        .clk   (clk),
        .reset (reset),
        .bus   (b1.slave)
    );

    logic [17:0] act0, act1;
    assign act0 = {b0.pcwrite, b0.irwrite, b0.memwrite, b0.regwrite, b0.iord, b0.alusrca,
                   b0.regdst, b0.memtoreg, b0.branch, b0.bne, b0.ori, b0.illegal,
                   b0.alusrcb, b0.pcsrc, b0.aluop};
    assign act1 = {b1.pcwrite, b1.irwrite, b1.memwrite, b1.regwrite, b1.iord, b1.alusrca,
                   b1.regdst, b1.memtoreg, b1.branch, b1.bne, b1.ori, b1.illegal,
                   b1.alusrcb, b1.pcsrc, b1.aluop};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor: every queued expectation is checked on the falling edge
    always @(negedge clk) begin
        sb_entry_t   e;
        logic [3:0]  ast;
        logic [17:0] ao;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            ast = (e.sel == 0) ? b0.state : b1.state;
            ao  = (e.sel == 0) ? act0 : act1;
            total++;
            if (ast !== e.st || ao !== e.o) begin
                bad++;
                $display("FAIL %s: got state=%0d outs=%05h, want state=%0d outs=%05h",
                         e.nm, ast, ao, e.st, e.o);
            end
        end
    end

    initial begin
        #20000;
        bad++;
        $display("FAIL watchdog: wait for test completion expired");
        $finish;
    end

    task automatic expect_now(input int sel, input logic [3:0] st, input logic [17:0] o,
                              input string nm);
        sb_entry_t e;
        e = '{sel, st, o, nm};
        sb.push_back(e);
        queued++;
    endtask

    // called at posedge+1: drive inputs, queue this cycle's expectation, advance a cycle
    task automatic step(input int sel, input logic [5:0] op, input logic mr,
                        input logic [3:0] st, input logic [17:0] o, input string nm);
        if (sel == 0) begin
            b0.op = op;
            b0.mem_ready = mr;
        end else begin
            b1.op = op;
            b1.mem_ready = mr;
        end
        expect_now(sel, st, o, nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        queued = 0;
        reset  = 1'b1;
        b0.op = c_lw;
        b0.mem_ready = 1'b1;
        b1.op = c_rt;
        b1.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        expect_now(1, 4'd0, c_sb1, "rst_lite");
        step(0, c_lw, 1'b1, 4'd0, c_sb1, "rst_gated");
        reset = 1'b0;

        // LW, no stalls
        step(0, c_lw, 1'b1, 4'd0, c_fet, "lw_fetch");
        step(0, c_lw, 1'b1, 4'd1, c_sb3, "lw_decode");
        step(0, c_lw, 1'b1, 4'd2, c_asa | c_sb2, "lw_memadr");
        step(0, c_lw, 1'b1, 4'd3, c_iord, "lw_memrd");
        step(0, c_lw, 1'b1, 4'd4, c_rw | c_m2r, "lw_memwb");

        // SW with a fetch stall and three write stalls
        step(0, c_sw, 1'b0, 4'd0, c_sb1, "sw_fetch_stall");
        step(0, c_sw, 1'b1, 4'd0, c_fet, "sw_fetch");
        step(0, c_sw, 1'b1, 4'd1, c_sb3, "sw_decode");
        step(0, c_sw, 1'b1, 4'd2, c_asa | c_sb2, "sw_memadr");
        for (int i = 0; i < 3; i++)
            step(0, c_sw, 1'b0, 4'd5, c_iord | c_mw, "sw_memwr_stall");
        step(0, c_sw, 1'b1, 4'd5, c_iord | c_mw, "sw_memwr_done");

        // LW with a read stall
        step(0, c_lw, 1'b1, 4'd0, c_fet, "lws_fetch");
        step(0, c_lw, 1'b1, 4'd1, c_sb3, "lws_decode");
        step(0, c_lw, 1'b1, 4'd2, c_asa | c_sb2, "lws_memadr");
        step(0, c_lw, 1'b0, 4'd3, c_iord, "lws_memrd_stall");
        step(0, c_lw, 1'b1, 4'd3, c_iord, "lws_memrd");
        step(0, c_lw, 1'b1, 4'd4, c_rw | c_m2r, "lws_memwb");

        step(0, c_rt, 1'b1, 4'd0, c_fet, "rt_fetch");
        step(0, c_rt, 1'b1, 4'd1, c_sb3, "rt_decode");
        step(0, c_rt, 1'b1, 4'd6, c_asa | c_ao2, "rt_ex");
        step(0, c_rt, 1'b1, 4'd7, c_rdst | c_rw, "rt_wb");

        step(0, c_beq, 1'b1, 4'd0, c_fet, "beq_fetch");
        step(0, c_beq, 1'b1, 4'd1, c_sb3, "beq_decode");
        step(0, c_beq, 1'b1, 4'd8, c_asa | c_ao1 | c_pc1 | c_br, "beq_ex");

        step(0, c_bneop, 1'b1, 4'd0, c_fet, "bne_fetch");
        step(0, c_bneop, 1'b1, 4'd1, c_sb3, "bne_decode");
        step(0, c_bneop, 1'b1, 4'd12, c_asa | c_ao1 | c_pc1 | c_bne, "bne_ex");

        step(0, c_addi, 1'b1, 4'd0, c_fet, "addi_fetch");
        step(0, c_addi, 1'b1, 4'd1, c_sb3, "addi_decode");
        step(0, c_addi, 1'b1, 4'd9, c_asa | c_sb2, "addi_ex");
        step(0, c_addi, 1'b1, 4'd10, c_rw, "addi_wb");

        step(0, c_oriop, 1'b1, 4'd0, c_fet, "ori_fetch");
        step(0, c_oriop, 1'b1, 4'd1, c_sb3, "ori_decode");
        step(0, c_oriop, 1'b1, 4'd13, c_asa | c_sb2 | c_ao3 | c_ori, "ori_ex");
        step(0, c_oriop, 1'b1, 4'd10, c_rw, "ori_wb");

        step(0, c_j, 1'b1, 4'd0, c_fet, "j_fetch");
        step(0, c_j, 1'b1, 4'd1, c_sb3, "j_decode");
        step(0, c_j, 1'b1, 4'd11, c_pcw | c_pc2, "j_ex");

        step(0, c_bad, 1'b1, 4'd0, c_fet, "bad_fetch");
        step(0, c_bad, 1'b1, 4'd1, c_sb3 | c_ill, "bad_decode");
        step(0, c_bad, 1'b0, 4'd0, c_sb1, "bad_back");

        // reduced build: BNE and ORI are illegal
        step(1, c_bneop, 1'b1, 4'd0, c_fet, "lite_bne_fetch");
        step(1, c_bneop, 1'b1, 4'd1, c_sb3 | c_ill, "lite_bne_decode");
        step(1, c_oriop, 1'b1, 4'd0, c_fet, "lite_ori_fetch");
        step(1, c_oriop, 1'b1, 4'd1, c_sb3 | c_ill, "lite_ori_decode");
        step(1, c_oriop, 1'b0, 4'd0, c_sb1, "lite_back");

        // asynchronous reset in the middle of a stalled store
        step(0, c_sw, 1'b1, 4'd0, c_fet, "rsw_fetch");
        step(0, c_sw, 1'b1, 4'd1, c_sb3, "rsw_decode");
        step(0, c_sw, 1'b1, 4'd2, c_asa | c_sb2, "rsw_memadr");
        step(0, c_sw, 1'b0, 4'd5, c_iord | c_mw, "rsw_memwr");
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (b0.state !== 4'd0 || b0.memwrite !== 1'b0) begin
            bad++;
            $display("FAIL rsw_async_immediate: state=%0d memwrite=%b, want state=0 memwrite=0",
                     b0.state, b0.memwrite);
        end
        expect_now(0, 4'd0, c_sb1, "rsw_async_reset");
        @(posedge clk);
        #1;
        b0.mem_ready = 1'b1;
        expect_now(0, 4'd0, c_sb1, "rsw_reset_gate");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(0, c_j, 1'b1, 4'd0, c_fet, "post_rst_fetch");
        step(0, c_j, 1'b1, 4'd1, c_sb3, "post_rst_decode");
        step(0, c_j, 1'b0, 4'd11, c_pcw | c_pc2, "post_rst_jex");
        step(0, c_j, 1'b0, 4'd0, c_sb1, "post_rst_idle");

        @(negedge clk);
        #1;
        if (bad != 0 || total < queued) begin
            $display("FAIL summary: total=%0d queued=%0d bad=%0d", total, queued, bad);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_maindec.md
MC_MAINDEC -- requirements
Module: mc_maindec

Interface
REQ-001 Parameter SUPPORT_BNE, default 1, meaning 1 = opcode 000101 (BNE) decoded, 0 = treated as illegal.
REQ-002 Parameter SUPPORT_ORI, default 1, meaning 1 = opcode 001101 (ORI) decoded, 0 = treated as illegal.
REQ-003 Port clk, input, 1, meaning the single clock; all state changes occur on its rising edge.
REQ-004 Port reset, input, 1, meaning asynchronous active-high reset.
REQ-005 Port op, input, 6, meaning opcode from the instruction register, stable from DECODE until FETCH.
REQ-006 Port mem_ready, input, 1, meaning memory has completed the current access this cycle.
REQ-007 Ports pcwrite, irwrite, memwrite, regwrite, iord, alusrca, regdst, memtoreg, branch, bne, ori, output, 1 each, meaning datapath controls.
REQ-008 Ports alusrcb, pcsrc, aluop, output, 2 each, meaning datapath mux selects and ALU-decoder op class.
REQ-009 Port illegal, output, 1, meaning one-cycle pulse when an unsupported opcode is decoded.
REQ-010 Port state, output, 4, meaning current FSM state encoding, for debug and verification.

Function
REQ-011 The block SHALL be a Moore FSM; all outputs decode from state only, except that irwrite, pcwrite in FETCH and illegal in DECODE SHALL also depend on mem_ready and op respectively.
REQ-012 States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, IWB=10, JEX=11, BNEEX=12, ORIEX=13.
REQ-013 FETCH: iord=0, alusrcb=01, aluop=00, irwrite=pcwrite=mem_ready; stay while mem_ready=0, else DECODE.
REQ-014 DECODE: alusrcb=11, aluop=00; next by op: 100011/101011->MEMADR, 000000->RTYPEEX, 000100->BEQEX, 001000->ADDIEX, 000010->JEX, 000101->BNEEX (if SUPPORT_BNE), 001101->ORIEX (if SUPPORT_ORI), any other->FETCH with illegal=1.
REQ-015 MEMADR: alusrca=1, alusrcb=10, aluop=00; op 100011->MEMRD, 101011->MEMWR.
REQ-016 MEMRD: iord=1; stay while mem_ready=0, else MEMWB.
REQ-017 MEMWB: memtoreg=1, regwrite=1, regdst=0; ->FETCH.
REQ-018 MEMWR: iord=1, memwrite=1 held every cycle until mem_ready=1; ->FETCH on mem_ready=1.
REQ-019 RTYPEEX: alusrca=1, alusrcb=00, aluop=10; ->RTYPEWB. RTYPEWB: regdst=1, regwrite=1; ->FETCH.
REQ-020 BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1; ->FETCH. BNEEX: identical with bne=1, branch=0.
REQ-021 ADDIEX: alusrca=1, alusrcb=10, aluop=00; ->IWB. ORIEX: alusrca=1, alusrcb=10, aluop=11, ori=1; ->IWB.
REQ-022 IWB: regwrite=1, regdst=0, memtoreg=0; ->FETCH.
REQ-023 JEX: pcsrc=10, pcwrite=1; ->FETCH.
REQ-024 Every output not listed for a state SHALL be 0; no output SHALL ever be X.
REQ-025 Latency with mem_ready=1 throughout: LW 5, SW/R-type/ADDI/ORI 4, BEQ/BNE/J 3 cycles; each stall cycle adds one.
REQ-026 Unreachable encodings 14-15 SHALL transition to FETCH with all outputs 0.

Reset
REQ-027 Assertion of reset SHALL force state to FETCH immediately, independent of clk, including mid-instruction or mid-stall.
REQ-028 While reset is asserted, pcwrite, irwrite, memwrite, regwrite and illegal SHALL be 0.
REQ-029 After deassertion the first rising edge SHALL evaluate FETCH normally.

Structure
REQ-030 State enum (4-bit) and opcode constants SHALL live in shared package mips_pkg for reuse by datapath and bench.
REQ-031 No sub-module; state register and output decode in one module, aluop encoding unchanged for the existing ALU decoder.

Verification
REQ-032 Reset mid-MEMWR with mem_ready=0 -> state=0 same cycle, memwrite=0 asynchronously.
REQ-033 op=100011, mem_ready=1 -> states 0,1,2,3,4,0; regwrite=1 only in cycle 5, memtoreg=1.
REQ-034 op=101011, mem_ready low 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles, then state=0.
REQ-035 SUPPORT_BNE=0, op=000101 -> illegal=1 in DECODE for one cycle, next state=0, no write enables asserted.
REQ-036 op=001101, SUPPORT_ORI=1 -> states 0,1,13,10,0; ori=1 and aluop=11 in ORIEX only.
REQ-037 op=000010 -> states 0,1,11,0; pcwrite=1, pcsrc=10 in JEX.
